onehot_scan_decoder: RTL

Parametrised registered binary-to-one-hot decoder, the successor to the combinational 3-to-8 decoder. It adds a valid/ready command interface, a held DECODE mode, and auto-scanning UP/DOWN modes with a programmable dwell prescaler. It drives LED/digit-select and row-strobe lines from a controller that issues commands instead of holding a select steady.

---
 rtl/onehot_scan_decoder_pkg.sv | 28 ++
 rtl/scan_prescaler.sv | 37 +++
 rtl/onehot_scan_decoder.sv | 111 +++++++++++
 3 files changed

// File: rtl/onehot_scan_decoder_pkg.sv
// Shared types and helpers for the registered one-hot scan decoder.
// Widths here are upper bounds; the top truncates to its own OUT_W.
package onehot_scan_decoder_pkg;

  localparam int unsigned SEL_W_MAX = 8;
  localparam int unsigned OUT_W_MAX = 1 << SEL_W_MAX;

  typedef enum logic [1:0] {
    DECODE    = 2'b00,
    SCAN_UP   = 2'b01,
    SCAN_DOWN = 2'b10,
    BLANK     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  function automatic logic [OUT_W_MAX-1:0] onehot(input logic [SEL_W_MAX-1:0] sel);
    logic [OUT_W_MAX-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Dwell prescaler: counts enabled cycles and ticks when the count reaches div.
// A tick returns the count to zero, so each dwell lasts div+1 enabled cycles.
module scan_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] cnt,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = en & (cnt_q == div);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with held decode, blanking and
// auto-scan modes driven through a valid/ready command port.
module onehot_scan_decoder
  import onehot_scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [DIV_W-1:0]       in_div,
  input  logic                   en,
  output logic [(1<<SEL_W)-1:0]  out,
  output logic                   out_valid,
  output logic [SEL_W-1:0]       idx,
  output logic                   wrap
);

  localparam int unsigned OUT_W = 1 << SEL_W;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               dir_up_q, dir_up_d;
  logic               wrap_q, wrap_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               out_valid_q;
  logic               in_scan, tick, accept;
  logic [DIV_W-1:0]   cnt_unused;
  mode_e              mode;

  assign in_scan = (state_q == SCAN);
  assign mode    = mode_e'(in_mode);

  // Outside SCAN the prescaler is frozen; a scan command restarts it at zero.
  scan_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (en & in_scan),
    .div  (div_q),
    .cnt  (cnt_unused),
    .tick (tick)
  );

  assign in_ready = ~in_scan | tick;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    div_d    = div_q;
    dir_up_d = dir_up_q;
    wrap_d   = 1'b0;
    if (accept) begin
      unique case (mode)
        DECODE: begin
          idx_d   = in_sel;
          state_d = HOLD;
        end
        SCAN_UP, SCAN_DOWN: begin
          idx_d    = in_sel;
          div_d    = in_div;
          dir_up_d = (mode == SCAN_UP);
          state_d  = SCAN;
        end
        default: state_d = IDLE;
      endcase
    end else if (in_scan && tick) begin
      // A command landing on the same tick takes priority over this step.
      if (dir_up_q) begin
        idx_d  = idx_q + 1'b1;
        wrap_d = (idx_q == {SEL_W{1'b1}});
      end else begin
        idx_d  = idx_q - 1'b1;
        wrap_d = (idx_q == '0);
      end
    end
    out_d = (state_d == IDLE) ? '0 : OUT_W'(onehot(SEL_W_MAX'(idx_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      div_q       <= '0;
      dir_up_q    <= 1'b1;
      wrap_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      div_q       <= div_d;
      dir_up_q    <= dir_up_d;
      wrap_q      <= wrap_d;
      out_q       <= out_d;
      out_valid_q <= (out_d != '0);
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign idx       = idx_q;
  assign wrap      = wrap_q;

endmodule
